// File: rtl/scalar_driver.sv
// scalar_driver: initiator for the scalar unit handshake.
// Takes one command, then for each of cmd_len vectors it reads operand 1 and
// operand 2 from a single-read-port buffer, issues them to the scalar unit,
// waits for DONE (bounded by TIMEOUT), writes the result back, and waits for
// the unit to return to IDLE before moving on.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for cmd_valid
// RD1    | read strobe on src1+k
// RD2    | read strobe on src2+k, capture operand 1 returning from RD1
// CAP    | capture operand 2, load scalar-unit operand and mode registers
// ISSUE  | pulse input_ready once the scalar unit reports IDLE
// WAIT   | wait for DONE; timer expiry sets err and aborts to FIN
// WRITE  | write sc_out to dst+k, pulse output_taken
// DRAIN  | wait for scalar unit IDLE, advance k, loop or finish
// FIN    | command complete; done pulses on the following cycle
module scalar_driver #(
    parameter int IL      = 4,
    parameter int FL      = 16,
    parameter int size    = 16,
    parameter int AW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [AW-1:0]            cmd_src1,
    input  logic [AW-1:0]            cmd_src2,
    input  logic [AW-1:0]            cmd_dst,
    input  logic [AW-1:0]            cmd_len,
    output logic                     rd_en,
    output logic [AW-1:0]            rd_addr,
    input  logic [(IL+FL)*size-1:0]  rd_data,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [(IL+FL)*size-1:0]  wr_data,
    output logic [1:0]               sc_mode,
    output logic                     sc_input_ready,
    output logic                     sc_output_taken,
    output logic [(IL+FL)*size-1:0]  sc_in1,
    output logic [(IL+FL)*size-1:0]  sc_in2,
    input  logic [1:0]               sc_state,
    input  logic [(IL+FL)*size-1:0]  sc_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int W  = IL + FL;
    localparam int VW = W * size;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] SC_IDLE = 2'b00;
    localparam logic [1:0] SC_DONE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_CAP,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [AW-1:0]   src1_q;
    logic [AW-1:0]   src2_q;
    logic [AW-1:0]   dst_q;
    logic [AW-1:0]   len_q;
    logic [AW-1:0]   k;
    logic [AW-1:0]   k_inc;
    logic [VW-1:0]   op1_q;
    logic [TW-1:0]   tmr;

    assign k_inc = k + AW'(1);

    // input_ready must follow the unit's state in the same cycle, so it is
    // the only strobe decoded combinationally from the state register.
    assign sc_input_ready = (state == S_ISSUE) && (sc_state == SC_IDLE);

    // Result goes straight through to the buffer; held at zero outside WRITE.
    assign wr_data = wr_en ? sc_out : '0;

    // Sequencer with registered outputs: each output is set on the
    // transition into the state where it must be visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            mode_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            dst_q           <= '0;
            len_q           <= '0;
            k               <= '0;
            op1_q           <= '0;
            tmr             <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            sc_output_taken <= 1'b0;
            sc_mode         <= '0;
            sc_in1          <= '0;
            sc_in2          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q    <= cmd_mode;
                        src1_q    <= cmd_src1;
                        src2_q    <= cmd_src2;
                        dst_q     <= cmd_dst;
                        len_q     <= cmd_len;
                        k         <= '0;
                        err       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= S_FIN;
                        end else begin
                            state   <= S_RD1;
                            rd_en   <= 1'b1;
                            rd_addr <= cmd_src1;
                        end
                    end
                end
                S_RD1: begin
                    state   <= S_RD2;
                    rd_addr <= src2_q + k;
                end
                S_RD2: begin
                    // Operand 1 returns now, one cycle after its RD1 strobe.
                    op1_q   <= rd_data;
                    rd_en   <= 1'b0;
                    rd_addr <= '0;
                    state   <= S_CAP;
                end
                S_CAP: begin
                    // Operands and mode change together here so the unit
                    // sees a coherent set from ISSUE until the next CAP.
                    sc_in1  <= op1_q;
                    sc_in2  <= rd_data;
                    sc_mode <= mode_q;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (sc_state == SC_IDLE) begin
                        tmr   <= TW'(TIMEOUT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sc_state == SC_DONE) begin
                        wr_en           <= 1'b1;
                        wr_addr         <= dst_q + k;
                        sc_output_taken <= 1'b1;
                        state           <= S_WRITE;
                    end else if (tmr == '0) begin
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_WRITE: begin
                    wr_en           <= 1'b0;
                    wr_addr         <= '0;
                    sc_output_taken <= 1'b0;
                    state           <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (sc_state == SC_IDLE) begin
                        k <= k_inc;
                        if (k_inc == len_q) begin
                            state <= S_FIN;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= src1_q + k_inc;
                            state   <= S_RD1;
                        end
                    end
                end
                S_FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_driver.sv
// Bench for scalar_driver: buffer model, behavioural scalar unit, table of
// commands plus hand-written timeout and mid-command reset sequences.
module tb_scalar_driver;

    localparam int IL      = 4;
    localparam int FL      = 16;
    localparam int SIZE    = 16;
    localparam int AW      = 8;
    localparam int TIMEOUT = 64;
    localparam int W       = IL + FL;
    localparam int VW      = W * SIZE;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_mode;
    logic [AW-1:0]   cmd_src1, cmd_src2, cmd_dst, cmd_len;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [VW-1:0]   rd_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [VW-1:0]   wr_data;
    logic [1:0]      sc_mode;
    logic            sc_input_ready;
    logic            sc_output_taken;
    logic [VW-1:0]   sc_in1, sc_in2;
    logic [1:0]      sc_state;
    logic [VW-1:0]   sc_out;
    logic            busy, done, err;

    scalar_driver #(.IL(IL), .FL(FL), .size(SIZE), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sc_mode(sc_mode), .sc_input_ready(sc_input_ready), .sc_output_taken(sc_output_taken),
        .sc_in1(sc_in1), .sc_in2(sc_in2), .sc_state(sc_state), .sc_out(sc_out),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer contents: src1 region 2j+1, src2 region j, each vector offset by
    // its address so a wrong k shows up in the data.
    function automatic logic [VW-1:0] mem_vec(input logic [AW-1:0] a);
        logic [VW-1:0] v;
        int e;
        int ai;
        ai = int'(a);
        for (int j = 0; j < SIZE; j++) begin
            if (ai < 16)      e = 2 * j + 1 + 64 * ai;
            else if (ai < 32) e = j + 64 * (ai - 16);
            else              e = 37 * ai + j;
            v[j*W +: W] = W'(e);
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] stub_op(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                              input logic [1:0] m);
        logic [VW-1:0] r;
        logic [W-1:0] x, y;
        for (int j = 0; j < SIZE; j++) begin
            x = a[j*W +: W];
            y = b[j*W +: W];
            case (m)
                2'd0:    r[j*W +: W] = x + y;
                2'd1:    r[j*W +: W] = x - y;
                2'd2:    r[j*W +: W] = x & y;
                default: r[j*W +: W] = x ^ y;
            endcase
        end
        return r;
    endfunction

    // Buffer read port: data one cycle after the strobe.
    always @(posedge clk) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem_vec(rd_addr);
    end

    // Scalar unit model: IDLE -> (BUSY for lat cycles) -> DONE until taken.
    logic [1:0]    st;
    int            scnt;
    int            lat;
    logic          hang;
    logic          stub_clr;
    logic [VW-1:0] sout;

    always @(posedge clk) begin
        if (reset || stub_clr) begin
            st   <= 2'd0;
            scnt <= 0;
            sout <= '0;
        end else begin
            case (st)
                2'd0: if (sc_input_ready) begin
                    sout <= stub_op(sc_in1, sc_in2, sc_mode);
                    if (hang)          st <= 2'd1;
                    else if (lat == 0) st <= 2'd2;
                    else begin
                        st   <= 2'd1;
                        scnt <= lat;
                    end
                end
                2'd1: if (!hang) begin
                    if (scnt <= 1) st <= 2'd2;
                    else           scnt <= scnt - 1;
                end
                2'd2: if (sc_output_taken) st <= 2'd0;
                default: st <= 2'd0;
            endcase
        end
    end

    assign sc_state = st;
    assign sc_out   = (st == 2'd2) ? sout : '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_log[$];
    logic [VW-1:0] wd_log[$];
    int   n_ir, n_ot, n_nodone, n_modebad;
    int   done_at, first_ir, first_err;
    logic err_at_done;

    // Present one command, then log every cycle until done or budget expiry.
    task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [AW-1:0] d, input logic [AW-1:0] ln, input int budget);
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();
        n_ir = 0; n_ot = 0; n_nodone = 0; n_modebad = 0;
        done_at = -1; first_ir = -1; first_err = -1; err_at_done = 1'bx;
        chk("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_mode = m; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_len = ln;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            if (rd_en) rd_log.push_back(rd_addr);
            if (wr_en) begin
                wr_log.push_back(wr_addr);
                wd_log.push_back(wr_data);
                if (st != 2'd2) n_nodone++;
                if (sc_mode !== m) n_modebad++;
            end
            if (sc_input_ready) begin
                n_ir++;
                if (first_ir < 0) first_ir = i;
                if (sc_mode !== m) n_modebad++;
            end
            if (sc_output_taken) n_ot++;
            if (err === 1'b1 && first_err < 0) first_err = i;
            if (done) begin
                done_at     = i;
                err_at_done = err;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done_within_budget", (done_at >= 0) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic [AW-1:0] d;
        logic [AW-1:0] len;
        int            lat;
        int            exp_hs;
        int            exp_cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ea;
        int            wait_cnt;
        int            strobes;

        // per-vector cycles with a same-cycle-ready unit: 7 + lat; plus 2 for accept/FIN
        vecs[0] = '{2'd0, 8'h00, 8'h10, 8'h20, 8'd1, 0, 1, 9};
        vecs[1] = '{2'd0, 8'h00, 8'h10, 8'h20, 8'd4, 0, 4, 30};
        vecs[2] = '{2'd1, 8'h00, 8'h10, 8'h40, 8'd2, 1, 2, 18};
        vecs[3] = '{2'd2, 8'h00, 8'h10, 8'h50, 8'd3, 0, 3, 23};
        vecs[4] = '{2'd3, 8'h04, 8'h14, 8'h60, 8'd2, 2, 2, 20};
        vecs[5] = '{2'd1, 8'h00, 8'h10, 8'h20, 8'd0, 0, 0, 2};
        vecs[6] = '{2'd2, 8'hFE, 8'h10, 8'hFE, 8'd3, 0, 3, 23};

        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0;
        cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_len = '0;
        lat = 0; hang = 1'b0; stub_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_input_ready", sc_input_ready, 0);
        chk("rst_output_taken", sc_output_taken, 0);
        chk("rst_sc_mode", sc_mode, 0);
        chkv("rst_sc_in1", sc_in1, '0);
        chkv("rst_sc_in2", sc_in2, '0);
        chkv("rst_wr_data", wr_data, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            lat = vecs[v].lat;
            run_cmd(vecs[v].mode, vecs[v].s1, vecs[v].s2, vecs[v].d, vecs[v].len, 200);
            chk($sformatf("v%0d_done_cycle", v), done_at, vecs[v].exp_cyc);
            chk($sformatf("v%0d_err", v), err_at_done, 0);
            chk($sformatf("v%0d_input_ready_count", v), n_ir, vecs[v].exp_hs);
            chk($sformatf("v%0d_output_taken_count", v), n_ot, vecs[v].exp_hs);
            chk($sformatf("v%0d_read_count", v), rd_log.size(), 2 * vecs[v].exp_hs);
            chk($sformatf("v%0d_write_count", v), wr_log.size(), vecs[v].exp_hs);
            chk($sformatf("v%0d_write_without_done", v), n_nodone, 0);
            chk($sformatf("v%0d_sc_mode", v), n_modebad, 0);
            for (int k = 0; k < vecs[v].exp_hs; k++) begin
                if (2 * k + 1 < rd_log.size()) begin
                    ea = vecs[v].s1 + AW'(k);
                    chk($sformatf("v%0d_rd1_addr_%0d", v, k), rd_log[2*k], ea);
                    ea = vecs[v].s2 + AW'(k);
                    chk($sformatf("v%0d_rd2_addr_%0d", v, k), rd_log[2*k+1], ea);
                end
                if (k < wr_log.size()) begin
                    ea = vecs[v].d + AW'(k);
                    chk($sformatf("v%0d_wr_addr_%0d", v, k), wr_log[k], ea);
                    chkv($sformatf("v%0d_wr_data_%0d", v, k), wd_log[k],
                         stub_op(mem_vec(vecs[v].s1 + AW'(k)), mem_vec(vecs[v].s2 + AW'(k)),
                                 vecs[v].mode));
                end
            end
        end

        // Scalar unit stuck in BUSY: timeout after TIMEOUT cycles of WAIT.
        hang = 1'b1;
        lat  = 0;
        run_cmd(2'd1, 8'h00, 8'h10, 8'h30, 8'd2, 200);
        chk("to_input_ready_count", n_ir, 1);
        chk("to_err_latency", first_err - first_ir, TIMEOUT + 1);
        chk("to_done_cycle", done_at, 70);
        chk("to_err_at_done", err_at_done, 1);
        chk("to_write_count", wr_log.size(), 0);
        chk("to_output_taken_count", n_ot, 0);
        hang = 1'b0;
        stub_clr = 1'b1;
        @(posedge clk); #1;
        stub_clr = 1'b0;
        chk("to_err_sticky", err, 1);
        run_cmd(2'd0, 8'h00, 8'h10, 8'h20, 8'd1, 200);
        chk("to_err_cleared_on_accept", first_err, -1);
        chk("to_next_done_cycle", done_at, 9);
        chk("to_next_write_count", wr_log.size(), 1);

        // Reset while the driver sits in WAIT.
        lat = 6;
        cmd_mode = 2'd0; cmd_src1 = 8'h00; cmd_src2 = 8'h10; cmd_dst = 8'h70; cmd_len = 8'd2;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_cnt = 0;
        while (!sc_input_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("rw_reached_issue", sc_input_ready, 1);
        @(posedge clk); #1;
        chk("rw_busy_in_wait", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rw_rd_en", rd_en, 0);
        chk("rw_wr_en", wr_en, 0);
        chk("rw_input_ready", sc_input_ready, 0);
        chk("rw_output_taken", sc_output_taken, 0);
        chk("rw_cmd_ready", cmd_ready, 1);
        chk("rw_busy", busy, 0);
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (rd_en || wr_en || sc_input_ready || sc_output_taken || done) strobes++;
        end
        chk("rw_no_activity_after_reset", strobes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
